// File: rtl/array_seq_pkg.sv
// rtl/array_seq_pkg.sv - shared op encoding, FSM states and helpers for array_sequencer
package array_seq_pkg;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_READ_Q  = 2'b01,
        OP_READ_QB = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRECH   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_SENSE   = 3'd3,
        ST_RECOVER = 3'd4
    } state_e;

    function automatic logic op_is_read(input op_e op);
        return (op == OP_READ_Q) || (op == OP_READ_QB);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/array_sequencer_row_decoder.sv
// rtl/array_sequencer_row_decoder.sv - binary row address plus enable to one-hot word-line vector
//
// Ports:
//   addr_i   - binary row index
//   en_i     - when low the output is all zeros
//   onehot_o - one-hot row select (combinational; the top registers it)
module row_decoder #(
    parameter int ROWS = 16,
    parameter int AW   = 4
) (
    input  logic [AW-1:0]   addr_i,
    input  logic            en_i,
    output logic [ROWS-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (en_i && (addr_i == AW'(r))) begin
                onehot_o[r] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/array_sequencer.sv
// rtl/array_sequencer.sv - precharge/access/sense sequencer for a ROWS x WIDTH memory array
//
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   cmd_valid/cmd_ready          - command handshake (ready only while idle)
//   cmd_op, cmd_addr, cmd_wdata  - command op, target row, write data
//   preb, w_en, sae              - active-low precharge, write-driver enable, sense-amp enable
//   wl, wlb                      - one-hot true/complement word lines
//   write_bits                   - data presented to the write drivers
//   sa_out                       - sense-amp result from the array
//   rdata, rdata_valid, err      - read result, read-complete pulse, dropped-command pulse
module array_sequencer
    import array_seq_pkg::*;
#(
    parameter int ROWS    = 16,
    parameter int WIDTH   = 8,
    parameter int PRE_CYC = 2,
    parameter int ACC_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [$clog2(ROWS)-1:0]  cmd_addr,
    input  logic [WIDTH-1:0]         cmd_wdata,
    output logic                     preb,
    output logic                     w_en,
    output logic                     sae,
    output logic [ROWS-1:0]          wl,
    output logic [ROWS-1:0]          wlb,
    output logic [WIDTH-1:0]         write_bits,
    input  logic [WIDTH-1:0]         sa_out,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rdata_valid,
    output logic                     err
);

    localparam int AW   = $clog2(ROWS);
    localparam int MAXC = max2(PRE_CYC, ACC_CYC);
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;

    logic             cmd_ready_q, cmd_ready_d;
    logic             preb_q, preb_d;
    logic             w_en_q, w_en_d;
    logic             sae_q, sae_d;
    logic [ROWS-1:0]  wl_q, wl_d;
    logic [ROWS-1:0]  wlb_q, wlb_d;
    logic [WIDTH-1:0] write_bits_q, write_bits_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rdata_valid_q, rdata_valid_d;
    logic             err_q, err_d;

    logic             capture;
    logic             drive;
    logic             wl_en, wlb_en;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if ((cmd_op == OP_ILLEGAL) || (int'(cmd_addr) >= ROWS)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_PRECH;
                        cnt_d   = CW'(PRE_CYC - 1);
                        op_d    = op_e'(cmd_op);
                        addr_d  = cmd_addr;
                        wdata_d = cmd_wdata;
                    end
                end
            end
            ST_PRECH: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACCESS;
                    cnt_d   = CW'(ACC_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = op_is_read(op_q) ? ST_SENSE : ST_RECOVER;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_SENSE: begin
                state_d = ST_RECOVER;
                capture = 1'b1;
            end
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that every port comes
    // straight from a flop and still lines up with the state it belongs to.
    always_comb begin
        drive         = (state_d == ST_ACCESS) || (state_d == ST_SENSE);
        wl_en         = drive && (op_d != OP_READ_QB);
        wlb_en        = drive && (op_d != OP_READ_Q);
        preb_d        = drive;
        w_en_d        = (state_d == ST_ACCESS) && (op_d == OP_WRITE);
        sae_d         = (state_d == ST_SENSE);
        write_bits_d  = w_en_d ? wdata_d : '0;
        rdata_valid_d = (state_d == ST_RECOVER) && op_is_read(op_d);
        cmd_ready_d   = (state_d == ST_IDLE);
        // The QB path senses the complement cell, so invert to get the stored word back.
        rdata_d       = rdata_q;
        if (capture) begin
            rdata_d = (op_q == OP_READ_QB) ? ~sa_out : sa_out;
        end
    end

    row_decoder #(.ROWS(ROWS), .AW(AW)) u_dec_wl (
        .addr_i   (addr_d),
        .en_i     (wl_en),
        .onehot_o (wl_d)
    );

    row_decoder #(.ROWS(ROWS), .AW(AW)) u_dec_wlb (
        .addr_i   (addr_d),
        .en_i     (wlb_en),
        .onehot_o (wlb_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            op_q          <= OP_WRITE;
            addr_q        <= '0;
            wdata_q       <= '0;
            cmd_ready_q   <= 1'b1;
            preb_q        <= 1'b0;
            w_en_q        <= 1'b0;
            sae_q         <= 1'b0;
            wl_q          <= '0;
            wlb_q         <= '0;
            write_bits_q  <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cmd_ready_q   <= cmd_ready_d;
            preb_q        <= preb_d;
            w_en_q        <= w_en_d;
            sae_q         <= sae_d;
            wl_q          <= wl_d;
            wlb_q         <= wlb_d;
            write_bits_q  <= write_bits_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            err_q         <= err_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign preb        = preb_q;
    assign w_en        = w_en_q;
    assign sae         = sae_q;
    assign wl          = wl_q;
    assign wlb         = wlb_q;
    assign write_bits  = write_bits_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign err         = err_q;

endmodule
